// File: rtl/key_debounce_pulse.sv
// Push-button front end: two-flop synchronizer, debounce FSM, and registered
// PRESS/RELEASE/STEP pulses with optional auto-repeat while the key is held.
module key_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int KEY_ACTIVE_HIGH = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY,
    input  logic REPEAT_EN,
    output logic PRESS,
    output logic RELEASE,
    output logic STEP,
    output logic KEY_STATE
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state, state_n;
    logic          sync1, sync2, k;
    logic [DW-1:0] db_cnt, db_n;
    logic [RW-1:0] rc, rc_n;
    logic          first, first_n;
    logic          press_n, release_n, step_n, level_n;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    assign k = (KEY_ACTIVE_HIGH != 0) ? sync2 : ~sync2;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            db_cnt    <= '0;
            rc        <= '0;
            first     <= 1'b1;
            PRESS     <= 1'b0;
            RELEASE   <= 1'b0;
            STEP      <= 1'b0;
            KEY_STATE <= 1'b0;
        end else begin
            state     <= state_n;
            db_cnt    <= db_n;
            rc        <= rc_n;
            first     <= first_n;
            PRESS     <= press_n;
            RELEASE   <= release_n;
            STEP      <= step_n;
            KEY_STATE <= level_n;
        end
    end

    always_comb begin
        state_n   = state;
        db_n      = db_cnt;
        rc_n      = rc;
        first_n   = first;
        press_n   = 1'b0;
        release_n = 1'b0;
        step_n    = 1'b0;
        level_n   = KEY_STATE;
        case (state)
            IDLE: begin
                if (k) begin
                    state_n = PRESS_WAIT;
                    db_n    = '0;
                end
            end
            PRESS_WAIT: begin
                if (!k) begin
                    state_n = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_n = HELD;
                    db_n    = '0;
                    press_n = 1'b1;
                    step_n  = 1'b1;
                    level_n = 1'b1;
                    rc_n    = '0;
                    first_n = 1'b1;
                end else begin
                    db_n = db_cnt + 1'b1;
                end
            end
            HELD: begin
                // Leaving for RELEASE_WAIT takes priority over a due repeat STEP;
                // the repeat counter stays frozen until the key is confirmed held.
                if (!k) begin
                    state_n = RELEASE_WAIT;
                    db_n    = '0;
                end else if (!REPEAT_EN) begin
                    rc_n    = '0;
                    first_n = 1'b1;
                end else if (rc == (first ? DELAY_LAST : PER_LAST)) begin
                    step_n  = 1'b1;
                    rc_n    = '0;
                    first_n = 1'b0;
                end else begin
                    rc_n = rc + 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (k) begin
                    state_n = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_n   = IDLE;
                    db_n      = '0;
                    release_n = 1'b1;
                    level_n   = 1'b0;
                end else begin
                    db_n = db_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed and random stimulus for key_debounce_pulse, checked cycle by cycle
// against a run-length model of the debounce and auto-repeat rules.
module tb_key_debounce_pulse;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic KEY = 1'b0;
    logic REPEAT_EN = 1'b0;
    logic PRESS, RELEASE, STEP, KEY_STATE;

    int errors = 0;
    int checks = 0;
    int npress = 0;
    int nrel = 0;
    int nstep = 0;

    // reference model state
    logic h1 = 1'b0, h2 = 1'b0;
    logic level = 1'b0;
    int   run = 0;
    int   n = 0;
    logic first = 1'b1;
    logic e_press = 1'b0, e_rel = 1'b0, e_step = 1'b0;

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .KEY_ACTIVE_HIGH(1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .KEY(KEY),
        .REPEAT_EN(REPEAT_EN),
        .PRESS(PRESS),
        .RELEASE(RELEASE),
        .STEP(STEP),
        .KEY_STATE(KEY_STATE)
    );

    always #5 CLK = ~CLK;

    // Model: the level flips once D+1 consecutive synchronized samples disagree
    // with it; repeat time accrues only on confirmed-held samples.
    task automatic model_edge();
        logic ks;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_step  = 1'b0;
        if (!RST) begin
            h1 = 1'b0; h2 = 1'b0; level = 1'b0; run = 0; n = 0; first = 1'b1;
        end else begin
            ks = h2;
            h2 = h1;
            h1 = KEY;
            if (ks != level) begin
                run++;
                if (run == D + 1) begin
                    level = ks;
                    run = 0;
                    if (level) begin
                        e_press = 1'b1; e_step = 1'b1; n = 0; first = 1'b1;
                    end else begin
                        e_rel = 1'b1;
                    end
                end
            end else begin
                if (level && run == 0) begin
                    if (REPEAT_EN) begin
                        n++;
                        if (n == (first ? RD : RP)) begin
                            e_step = 1'b1; n = 0; first = 1'b0;
                        end
                    end else begin
                        n = 0; first = 1'b1;
                    end
                end
                run = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        checks++;
        assert (PRESS === e_press) else begin
            errors++;
            $error("FAIL press obs=%0b exp=%0b t=%0t", PRESS, e_press, $time);
        end
        checks++;
        assert (RELEASE === e_rel) else begin
            errors++;
            $error("FAIL release obs=%0b exp=%0b t=%0t", RELEASE, e_rel, $time);
        end
        checks++;
        assert (STEP === e_step) else begin
            errors++;
            $error("FAIL step obs=%0b exp=%0b t=%0t", STEP, e_step, $time);
        end
        checks++;
        assert (KEY_STATE === level) else begin
            errors++;
            $error("FAIL key_state obs=%0b exp=%0b t=%0t", KEY_STATE, level, $time);
        end
        if (PRESS === 1'b1) npress++;
        if (RELEASE === 1'b1) nrel++;
        if (STEP === 1'b1) nstep++;
    endtask

    task automatic hold(input logic key, input int cycles);
        KEY = key;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic check_count(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with key held, then release reset
        RST = 1'b0; KEY = 1'b1; REPEAT_EN = 1'b0;
        tick(); tick();
        RST = 1'b1;
        npress = 0; nstep = 0;
        hold(1'b1, 10);
        check_count("reset_press_count", npress, 1);
        check_count("reset_step_count", nstep, 1);
        hold(1'b0, 10);

        // bounce rejection
        npress = 0; nstep = 0;
        hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 10);
        check_count("bounce_press_count", npress, 0);
        check_count("bounce_step_count", nstep, 0);

        // clean press and release
        npress = 0; nrel = 0;
        hold(1'b1, 20); hold(1'b0, 12);
        check_count("clean_press_count", npress, 1);
        check_count("clean_release_count", nrel, 1);

        // auto-repeat: press at cycle 7, steps at +0,+10,+13,+16,+19, then disabled
        REPEAT_EN = 1'b1; nstep = 0;
        hold(1'b1, 27);
        check_count("repeat_step_count", nstep, 5);
        REPEAT_EN = 1'b0; nstep = 0;
        hold(1'b1, 20);
        check_count("repeat_off_steps", nstep, 0);
        hold(1'b0, 10);

        // release glitch while held with repeat on
        REPEAT_EN = 1'b1; npress = 0; nrel = 0;
        hold(1'b1, 15); hold(1'b0, 2); hold(1'b1, 20);
        check_count("glitch_press_count", npress, 1);
        check_count("glitch_release_count", nrel, 0);
        hold(1'b0, 10);

        // reset mid-held, key still held
        REPEAT_EN = 1'b0; nrel = 0; npress = 0;
        hold(1'b1, 12);
        RST = 1'b0; tick(); RST = 1'b1;
        hold(1'b1, 10);
        check_count("midreset_release_count", nrel, 0);
        check_count("midreset_press_count", npress, 2);
        hold(1'b0, 10);

        // random runs of key levels, repeat enable and occasional reset
        for (int i = 0; i < 400; i++) begin
            REPEAT_EN = $urandom_range(0, 3) != 0;
            RST = $urandom_range(0, 49) != 0;
            KEY = $urandom_range(0, 1);
            for (int j = 0; j < int'($urandom_range(1, 14)); j++) begin
                tick();
                RST = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
